// File: rtl/rng_arbiter.sv
// Round-robin arbiter that hands out one 4-bit pseudo-random value per grant.
// The random state advances only on grants and can be reloaded via a seed strobe.
module rng_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            seed_valid_i,
  input  logic [3:0]      seed_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            rnd_valid_o,
  output logic [3:0]      rnd_o,
  output logic            busy_o,
  output logic [7:0]      gnt_cnt_o
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEED  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      rnd_q, rnd_d;
  logic            valid_q, valid_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win;
  logic [PW:0]     win_inc;
  logic [3:0]      s_step;

  assign s_step = {s_q[2], s_q[1] ^ s_q[3], s_q[0] ^ s_q[3], s_q[3]};

  // Last cycle's winner is masked so a request still held one edge after its grant is not served twice.
  always_comb begin
    elig  = req_i & ~gnt_q;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      logic [PW:0] sum;
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!found && elig[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  assign win_inc = {1'b0, win} + 1'b1;

  always_comb begin
    state_d = IDLE;
    s_d     = s_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (seed_valid_i) begin
      state_d = SEED;
      s_d     = (seed_i == 4'd0) ? 4'b0001 : seed_i;
    end else if (found) begin
      state_d = GRANT;
      gnt_d   = NREQ'(1) << win;
      rnd_d   = s_q;
      valid_d = 1'b1;
      s_d     = s_step;
      ptr_d   = (win_inc == (PW+1)'(NREQ)) ? '0 : win_inc[PW-1:0];
      cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= 4'b1111;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rnd_valid_o = valid_q;
  assign rnd_o       = rnd_q;
  assign busy_o      = (state_q == SEED);
  assign gnt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed self-checking bench for rng_arbiter with NREQ=4.
module tb_rng_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       seed_valid_i = 1'b0;
  logic [3:0] seed_i = '0;
  logic [3:0] req_i = '0;
  logic [3:0] gnt_o;
  logic       rnd_valid_o;
  logic [3:0] rnd_o;
  logic       busy_o;
  logic [7:0] gnt_cnt_o;

  int checks = 0;
  int errors = 0;

  rng_arbiter #(.NREQ(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .seed_valid_i (seed_valid_i),
    .seed_i       (seed_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_o        (rnd_o),
    .busy_o       (busy_o),
    .gnt_cnt_o    (gnt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [3:0] all_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] all_rnd [8] = '{4'b1111, 4'b1001, 4'b0101, 4'b1010, 4'b0011, 4'b0110, 4'b1100, 4'b1111};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    seed_valid_i = 1'b0;
    seed_i = '0;
    req_i = '0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt_o, rnd_valid_o, rnd_o, busy_o, gnt_cnt_o} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b valid=%b rnd=%b busy=%b cnt=%0d required all zero",
               gnt_o, rnd_valid_o, rnd_o, busy_o, gnt_cnt_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_i = 4'b0001;
    step();
    checks++;
    if (gnt_o !== 4'b0001 || rnd_o !== 4'b1111 || rnd_valid_o !== 1'b1 || gnt_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL single_grant gnt=%b rnd=%b valid=%b cnt=%0d required 0001 1111 1 1",
               gnt_o, rnd_o, rnd_valid_o, gnt_cnt_o);
    end
    step();
    checks++;
    if (gnt_o !== 4'b0000 || rnd_o !== 4'b0000 || rnd_valid_o !== 1'b0 || gnt_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL single_masked gnt=%b rnd=%b valid=%b cnt=%0d required 0000 0000 0 1",
               gnt_o, rnd_o, rnd_valid_o, gnt_cnt_o);
    end
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_all_req();
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (gnt_o !== all_gnt[i] || rnd_o !== all_rnd[i] || rnd_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL all_req[%0d] gnt=%b rnd=%b valid=%b required %b %b 1",
                 i, gnt_o, rnd_o, rnd_valid_o, all_gnt[i], all_rnd[i]);
      end
    end
    checks++;
    if (gnt_cnt_o !== 8'd8) begin
      errors++;
      $display("FAIL all_req_cnt got %0d required 8", gnt_cnt_o);
    end
    req_i = 4'b0000;
    step();
    checks++;
    if (gnt_o !== 4'b0000 || rnd_o !== 4'b0000 || rnd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle gnt=%b rnd=%b valid=%b required 0000 0000 0", gnt_o, rnd_o, rnd_valid_o);
    end
    step();
    req_i = 4'b0100;
    step();
    checks++;
    if (gnt_o !== 4'b0100 || rnd_o !== 4'b1001) begin
      errors++;
      $display("FAIL after_idle gnt=%b rnd=%b required 0100 1001", gnt_o, rnd_o);
    end
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_seed_zero();
    do_reset();
    req_i = 4'b0010;
    seed_valid_i = 1'b1;
    seed_i = 4'b0000;
    step();
    seed_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || gnt_o !== 4'b0000 || rnd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL seed_zero_busy busy=%b gnt=%b valid=%b required 1 0000 0", busy_o, gnt_o, rnd_valid_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || gnt_o !== 4'b0010 || rnd_o !== 4'b0001) begin
      errors++;
      $display("FAIL seed_zero_grant busy=%b gnt=%b rnd=%b required 0 0010 0001", busy_o, gnt_o, rnd_o);
    end
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_seed_vs_req();
    do_reset();
    req_i = 4'b0100;
    seed_valid_i = 1'b1;
    seed_i = 4'b0110;
    step();
    seed_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || gnt_o !== 4'b0000 || gnt_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL seed_wins busy=%b gnt=%b cnt=%0d required 1 0000 0", busy_o, gnt_o, gnt_cnt_o);
    end
    step();
    checks++;
    if (gnt_o !== 4'b0100 || rnd_o !== 4'b0110 || gnt_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL seeded_grant gnt=%b rnd=%b cnt=%0d required 0100 0110 1", gnt_o, rnd_o, gnt_cnt_o);
    end
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_seed_hold();
    do_reset();
    req_i = 4'b1000;
    seed_valid_i = 1'b1;
    seed_i = 4'b0011;
    step();
    seed_i = 4'b0101;
    step();
    seed_valid_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL seed_hold busy=%b gnt=%b required 1 0000", busy_o, gnt_o);
    end
    step();
    checks++;
    if (gnt_o !== 4'b1000 || rnd_o !== 4'b0101 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL seed_reload gnt=%b rnd=%b busy=%b required 1000 0101 0", gnt_o, rnd_o, busy_o);
    end
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_wrap();
    logic [3:0] model_s;
    logic [3:0] hist [256];
    int budget;
    do_reset();
    model_s = 4'b1111;
    req_i = 4'b0001;
    for (int n = 0; n < 256; n++) begin
      budget = 0;
      step();
      while (gnt_o === 4'b0000 && budget < 4) begin
        step();
        budget++;
      end
      checks++;
      if (gnt_o !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_timeout grant %0d gnt=%b required 0001", n, gnt_o);
        break;
      end
      hist[n] = rnd_o;
      checks++;
      if (rnd_o !== model_s || rnd_o === 4'd0) begin
        errors++;
        $display("FAIL wrap_rnd grant %0d got %b required %b", n, rnd_o, model_s);
      end
      if (n >= 7) begin
        checks++;
        if (rnd_o !== hist[n-7]) begin
          errors++;
          $display("FAIL wrap_period grant %0d got %b required %b", n, rnd_o, hist[n-7]);
        end
      end
      checks++;
      if (gnt_cnt_o !== 8'(n + 1)) begin
        errors++;
        $display("FAIL wrap_cnt grant %0d got %0d required %0d", n, gnt_cnt_o, 8'(n + 1));
      end
      model_s = {model_s[2], model_s[1] ^ model_s[3], model_s[0] ^ model_s[3], model_s[3]};
    end
    req_i = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_i = 4'b0010;
    step();
    checks++;
    if (gnt_o !== 4'b0010 || rnd_o !== 4'b1111) begin
      errors++;
      $display("FAIL pre_async gnt=%b rnd=%b required 0010 1111", gnt_o, rnd_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 4'b0000 || rnd_valid_o !== 1'b0 || rnd_o !== 4'b0000 || gnt_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL async_drop gnt=%b valid=%b rnd=%b cnt=%0d required 0000 0 0000 0",
               gnt_o, rnd_valid_o, rnd_o, gnt_cnt_o);
    end
    rst_i = 1'b0;
    req_i = 4'b0110;
    step();
    checks++;
    if (gnt_o !== 4'b0010 || rnd_o !== 4'b1111) begin
      errors++;
      $display("FAIL post_async gnt=%b rnd=%b required 0010 1111", gnt_o, rnd_o);
    end
    // Reset in the middle of a seed cycle throws the seed away.
    req_i = 4'b0000;
    seed_valid_i = 1'b1;
    seed_i = 4'b1010;
    step();
    seed_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL async_seed_busy got %b required 0", busy_o);
    end
    rst_i = 1'b0;
    req_i = 4'b0001;
    step();
    checks++;
    if (gnt_o !== 4'b0001 || rnd_o !== 4'b1111) begin
      errors++;
      $display("FAIL post_seed_reset gnt=%b rnd=%b required 0001 1111", gnt_o, rnd_o);
    end
    req_i = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_seed_zero();
    test_seed_vs_req();
    test_seed_hold();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
